// File: rtl/br_resolve_unit.sv
// ----------------------------------------------------------------------------
// br_resolve_unit
//   Producer side of the branch-predictor update path. Each fetched branch
//   pushes its prediction into an in-order in-flight FIFO. When the BRU
//   resolves the oldest branch, the head entry is popped and compared with the
//   actual outcome. The unit then drives a registered update pulse toward the
//   predictor and, on a mispredict, a registered redirect pulse.
//
// Ports
//   i_clk, i_rst           clock / async active-high reset
//   i_fetch_*              push side (pc, predicted dir, predicted target)
//   o_fetch_ready          FIFO not full
//   i_res_*                resolve side (pc, actual dir, actual target)
//   i_flush                external flush, discards every in-flight entry
//   o_update_*             one-cycle predictor update, registered
//   o_redirect[_pc]        one-cycle mispredict redirect, registered
//   o_pc_mismatch          sticky: resolve pc disagreed with head pc
//   o_br_cnt/o_mispred_cnt saturating performance counters
// ----------------------------------------------------------------------------
module br_resolve_unit #(
   parameter int DEPTH = 8,
   parameter int CNT_W = 32
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_fetch_valid,
   input  logic [31:0]      i_fetch_pc,
   input  logic             i_fetch_prd_taken,
   input  logic [31:0]      i_fetch_prd_target,
   output logic             o_fetch_ready,
   input  logic             i_res_valid,
   input  logic [31:0]      i_res_pc,
   input  logic             i_res_taken,
   input  logic [31:0]      i_res_target,
   input  logic             i_flush,
   output logic             o_update_en,
   output logic             o_update_valid,
   output logic             o_update_taken,
   output logic             o_update_already_prd,
   output logic [31:0]      o_update_pc,
   output logic [31:0]      o_update_target,
   output logic             o_redirect,
   output logic [31:0]      o_redirect_pc,
   output logic             o_pc_mismatch,
   output logic [CNT_W-1:0] o_br_cnt,
   output logic [CNT_W-1:0] o_mispred_cnt
);

   localparam int AW = $clog2(DEPTH);

   // entry storage
   logic [31:0] pc_mem  [DEPTH];
   logic        prd_mem [DEPTH];
   logic [31:0] tgt_mem [DEPTH];

   // pointers carry one extra wrap bit to tell full from empty
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;

   logic        full, empty, push, pop;
   logic [31:0] head_pc, head_tgt;
   logic        head_prd;
   logic        mispred, clear, pc_mis;
   logic [31:0] correct_pc;

   // output registers
   logic             upd_en_q, upd_taken_q, upd_prd_q;
   logic [31:0]      upd_pc_q, upd_tgt_q;
   logic             redir_q;
   logic [31:0]      redir_pc_q;
   logic             pc_mis_q;
   logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
   logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   assign push = i_fetch_valid & ~full;
   assign pop  = i_res_valid;

   // An empty-FIFO resolve compares against a "predicted not-taken" fallback
   always_comb begin
      head_pc  = i_res_pc;
      head_prd = 1'b0;
      head_tgt = 32'd0;
      if (!empty) begin
         head_pc  = pc_mem[rd_ptr_q[AW-1:0]];
         head_prd = prd_mem[rd_ptr_q[AW-1:0]];
         head_tgt = tgt_mem[rd_ptr_q[AW-1:0]];
      end
   end

   assign mispred    = pop & ((i_res_taken != head_prd) |
                              (i_res_taken & head_prd & (i_res_target != head_tgt)));
   assign correct_pc = i_res_taken ? i_res_target : (i_res_pc + 32'd4);
   assign pc_mis     = pop & ~empty & (i_res_pc != head_pc);

   // A mispredict makes every younger entry wrong-path, so it clears the FIFO
   // just like an external flush; a same-cycle push is dropped either way.
   assign clear = i_flush | mispred;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push)
            wr_ptr_d = wr_ptr_q + 1'b1;
         // empty pop uses the fallback head and leaves rd untouched, so a
         // simultaneous push on empty survives
         if (pop && !empty)
            rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   always_comb begin
      br_cnt_d  = br_cnt_q;
      mis_cnt_d = mis_cnt_q;
      if (pop && (br_cnt_q != {CNT_W{1'b1}}))
         br_cnt_d = br_cnt_q + 1'b1;
      if (mispred && (mis_cnt_q != {CNT_W{1'b1}}))
         mis_cnt_d = mis_cnt_q + 1'b1;
   end

   // storage needs no reset: occupancy is defined by the pointers alone
   always_ff @(posedge i_clk) begin
      if (push && !clear) begin
         pc_mem[wr_ptr_q[AW-1:0]]  <= i_fetch_pc;
         prd_mem[wr_ptr_q[AW-1:0]] <= i_fetch_prd_taken;
         tgt_mem[wr_ptr_q[AW-1:0]] <= i_fetch_prd_target;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         upd_en_q    <= 1'b0;
         upd_taken_q <= 1'b0;
         upd_prd_q   <= 1'b0;
         upd_pc_q    <= 32'd0;
         upd_tgt_q   <= 32'd0;
         redir_q     <= 1'b0;
         redir_pc_q  <= 32'd0;
         pc_mis_q    <= 1'b0;
         br_cnt_q    <= '0;
         mis_cnt_q   <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         br_cnt_q  <= br_cnt_d;
         mis_cnt_q <= mis_cnt_d;
         upd_en_q  <= pop;
         redir_q   <= mispred;
         if (pop) begin
            upd_taken_q <= i_res_taken;
            upd_prd_q   <= head_prd;
            upd_pc_q    <= i_res_pc;
            upd_tgt_q   <= i_res_target;
         end
         if (mispred)
            redir_pc_q <= correct_pc;
         if (pc_mis)
            pc_mis_q <= 1'b1;
      end
   end

   assign o_fetch_ready        = ~full;
   assign o_update_en          = upd_en_q;
   assign o_update_valid       = upd_en_q;
   assign o_update_taken       = upd_taken_q;
   assign o_update_already_prd = upd_prd_q;
   assign o_update_pc          = upd_pc_q;
   assign o_update_target      = upd_tgt_q;
   assign o_redirect           = redir_q;
   assign o_redirect_pc        = redir_pc_q;
   assign o_pc_mismatch        = pc_mis_q;
   assign o_br_cnt             = br_cnt_q;
   assign o_mispred_cnt        = mis_cnt_q;

endmodule

// File: tb/tb_br_resolve_unit.sv
module tb_br_resolve_unit;

   localparam int DEPTH = 8;
   localparam int CNT_W = 32;

   logic             i_clk = 1'b0;
   logic             i_rst = 1'b1;
   logic             i_fetch_valid = 1'b0;
   logic [31:0]      i_fetch_pc = '0;
   logic             i_fetch_prd_taken = 1'b0;
   logic [31:0]      i_fetch_prd_target = '0;
   logic             o_fetch_ready;
   logic             i_res_valid = 1'b0;
   logic [31:0]      i_res_pc = '0;
   logic             i_res_taken = 1'b0;
   logic [31:0]      i_res_target = '0;
   logic             i_flush = 1'b0;
   logic             o_update_en, o_update_valid, o_update_taken, o_update_already_prd;
   logic [31:0]      o_update_pc, o_update_target;
   logic             o_redirect;
   logic [31:0]      o_redirect_pc;
   logic             o_pc_mismatch;
   logic [CNT_W-1:0] o_br_cnt, o_mispred_cnt;

   int n_chk  = 0;
   int n_pass = 0;

   br_resolve_unit #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_fetch_valid(i_fetch_valid), .i_fetch_pc(i_fetch_pc),
      .i_fetch_prd_taken(i_fetch_prd_taken), .i_fetch_prd_target(i_fetch_prd_target),
      .o_fetch_ready(o_fetch_ready),
      .i_res_valid(i_res_valid), .i_res_pc(i_res_pc), .i_res_taken(i_res_taken),
      .i_res_target(i_res_target), .i_flush(i_flush),
      .o_update_en(o_update_en), .o_update_valid(o_update_valid),
      .o_update_taken(o_update_taken), .o_update_already_prd(o_update_already_prd),
      .o_update_pc(o_update_pc), .o_update_target(o_update_target),
      .o_redirect(o_redirect), .o_redirect_pc(o_redirect_pc),
      .o_pc_mismatch(o_pc_mismatch), .o_br_cnt(o_br_cnt), .o_mispred_cnt(o_mispred_cnt)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // one clock: inputs applied now are sampled at the edge, then dropped;
   // registered outputs are observed 1 time unit after the edge
   task automatic cyc();
      @(posedge i_clk);
      #1;
      i_fetch_valid = 1'b0;
      i_res_valid   = 1'b0;
      i_flush       = 1'b0;
   endtask

   task automatic set_push(input logic [31:0] pc, input logic prd, input logic [31:0] tgt);
      i_fetch_valid      = 1'b1;
      i_fetch_pc         = pc;
      i_fetch_prd_taken  = prd;
      i_fetch_prd_target = tgt;
   endtask

   task automatic set_res(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
      i_res_valid  = 1'b1;
      i_res_pc     = pc;
      i_res_taken  = tk;
      i_res_target = tgt;
   endtask

   initial begin
      // 1 reset
      #2;
      chk("rst_ready",   64'(o_fetch_ready), 64'd1);
      chk("rst_upd_en",  64'(o_update_en),   64'd0);
      chk("rst_redir",   64'(o_redirect),    64'd0);
      chk("rst_br_cnt",  64'(o_br_cnt),      64'd0);
      chk("rst_mis_cnt", 64'(o_mispred_cnt), 64'd0);
      @(posedge i_clk); #1; i_rst = 1'b0;

      // 2 correct taken prediction
      set_push(32'h100, 1'b1, 32'h200); cyc();
      set_res(32'h100, 1'b1, 32'h200);  cyc();
      chk("t2_upd_en",   64'(o_update_en),          64'd1);
      chk("t2_upd_vld",  64'(o_update_valid),       64'd1);
      chk("t2_already",  64'(o_update_already_prd), 64'd1);
      chk("t2_upd_pc",   64'(o_update_pc),          64'h100);
      chk("t2_upd_tgt",  64'(o_update_target),      64'h200);
      chk("t2_redir",    64'(o_redirect),           64'd0);
      chk("t2_br_cnt",   64'(o_br_cnt),             64'd1);
      cyc();
      chk("t2_upd_pulse", 64'(o_update_en),         64'd0);

      // 3 direction miss flushes the younger entry
      set_push(32'h100, 1'b0, 32'h0); cyc();
      set_push(32'h104, 1'b1, 32'h444); cyc();
      set_res(32'h100, 1'b1, 32'h80); cyc();
      chk("t3_redir",    64'(o_redirect),    64'd1);
      chk("t3_redir_pc", 64'(o_redirect_pc), 64'h80);
      chk("t3_mis_cnt",  64'(o_mispred_cnt), 64'd1);
      chk("t3_ready",    64'(o_fetch_ready), 64'd1);
      cyc();
      chk("t3_redir_pulse", 64'(o_redirect), 64'd0);
      // empty resolve: fallback head, predicted not-taken, so not-taken is correct
      set_res(32'h104, 1'b0, 32'h0); cyc();
      chk("t3_empty_prd",  64'(o_update_already_prd), 64'd0);
      chk("t3_empty_redir", 64'(o_redirect),          64'd0);
      chk("t3_br_cnt",     64'(o_br_cnt),             64'd3);

      // 4 fill to DEPTH, overflow push dropped, drain in order
      for (int i = 0; i < DEPTH; i++) begin
         set_push(32'h1000 + 32'(4 * i), 1'b0, 32'h0); cyc();
      end
      chk("t4_full", 64'(o_fetch_ready), 64'd0);
      set_push(32'hDEAD, 1'b1, 32'hBEEF); cyc();
      chk("t4_still_full", 64'(o_fetch_ready), 64'd0);
      for (int i = 0; i < DEPTH; i++) begin
         set_res(32'h1000 + 32'(4 * i), 1'b0, 32'h0); cyc();
         chk($sformatf("t4_pc%0d", i), 64'(o_update_pc), 64'(32'h1000 + 32'(4 * i)));
         chk($sformatf("t4_redir%0d", i), 64'(o_redirect), 64'd0);
      end
      chk("t4_order",   64'(o_pc_mismatch), 64'd0);
      chk("t4_ready",   64'(o_fetch_ready), 64'd1);
      chk("t4_br_cnt",  64'(o_br_cnt),      64'd11);
      // dropped 9th push must not be there
      set_res(32'h2000, 1'b0, 32'h0); cyc();
      chk("t4_no_ovf",  64'(o_update_already_prd), 64'd0);
      chk("t4_no_ovf_redir", 64'(o_redirect),      64'd0);

      // 5 wraparound fall-through
      set_push(32'hFFFF_FFFC, 1'b1, 32'h10); cyc();
      set_res(32'hFFFF_FFFC, 1'b0, 32'h0); cyc();
      chk("t5_redir",    64'(o_redirect),           64'd1);
      chk("t5_redir_pc", 64'(o_redirect_pc),        64'h0);
      chk("t5_already",  64'(o_update_already_prd), 64'd1);
      chk("t5_taken",    64'(o_update_taken),       64'd0);
      chk("t5_mis_cnt",  64'(o_mispred_cnt),        64'd2);

      // 6 flush with same-cycle resolve and push
      set_push(32'h500, 1'b1, 32'h600); cyc();
      i_flush = 1'b1;
      set_res(32'h500, 1'b1, 32'h600);
      set_push(32'h504, 1'b1, 32'h900);
      cyc();
      chk("t6_upd_en",   64'(o_update_en),          64'd1);
      chk("t6_already",  64'(o_update_already_prd), 64'd1);
      chk("t6_redir",    64'(o_redirect),           64'd0);
      chk("t6_ready",    64'(o_fetch_ready),        64'd1);
      set_res(32'h700, 1'b0, 32'h0); cyc();
      chk("t6_push_drop", 64'(o_update_already_prd), 64'd0);
      chk("t6_no_pcmis",  64'(o_pc_mismatch),        64'd0);
      chk("t6_br_cnt",    64'(o_br_cnt),             64'd15);

      // 7 push+pop on empty: pop takes fallback, pushed entry survives
      set_res(32'h900, 1'b0, 32'h0);
      set_push(32'h900, 1'b1, 32'h950);
      cyc();
      chk("t7_fallback", 64'(o_update_already_prd), 64'd0);
      set_res(32'h900, 1'b1, 32'h950); cyc();
      chk("t7_kept",     64'(o_update_already_prd), 64'd1);
      chk("t7_redir",    64'(o_redirect),           64'd0);
      // sticky pc mismatch
      set_push(32'h800, 1'b0, 32'h0); cyc();
      set_res(32'h804, 1'b0, 32'h0); cyc();
      chk("t7_pcmis",    64'(o_pc_mismatch), 64'd1);
      cyc(); cyc();
      chk("t7_pcmis_sticky", 64'(o_pc_mismatch), 64'd1);
      chk("t7_mis_cnt",  64'(o_mispred_cnt), 64'd2);

      // 8 reset mid-operation drops the pending pulse
      set_push(32'hA00, 1'b1, 32'hB00); cyc();
      set_res(32'hA00, 1'b0, 32'h0); cyc();
      chk("t8_pulse",   64'(o_redirect), 64'd1);
      i_rst = 1'b1; #1;
      chk("t8_rst_upd", 64'(o_update_en),   64'd0);
      chk("t8_rst_red", 64'(o_redirect),    64'd0);
      chk("t8_rst_cnt", 64'(o_br_cnt),      64'd0);
      chk("t8_rst_pcm", 64'(o_pc_mismatch), 64'd0);
      chk("t8_rst_rdy", 64'(o_fetch_ready), 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
